// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse meter.
//
// Contents:
//   DCNT_WIDTH      width of the debounce run counter; sized so that any
//                   legal debounce length (1 .. 2^16-1) fits
//   meterState_t    measurement FSM state encoding; 2'd3 is unused and
//                   recovers to IDLE
//   isMeasuring()   true while the FSM is tracking a phase
package pulse_meter_pkg;

    localparam int DCNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meterState_t;

    function automatic logic isMeasuring(input meterState_t s);
        return (s == HIGH) || (s == LOW);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Synchronizer plus debounce filter for one asynchronous board input.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_signal  raw asynchronous input
//   level      filtered level; follows a clean input edge after
//              SYNC_STAGES + DEBOUNCE_CYCLES cycles and ignores any pulse
//              shorter than DEBOUNCE_CYCLES cycles
module input_debounce
    import pulse_meter_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_signal,
    output logic level
);

    localparam logic [DCNT_WIDTH-1:0] DCNT_LAST = DCNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCNT_WIDTH-1:0] DCNT_ONE  = DCNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   syncOut;
    logic [DCNT_WIDTH-1:0]  dcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], in_signal};
        end
    end

    assign syncOut = syncChain[SYNC_STAGES-1];

    // dcnt measures how long the synchronized input has disagreed with the
    // filtered level; any agreeing cycle restarts the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dcnt  <= '0;
            level <= 1'b0;
        end else if (syncOut == level) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            level <= ~level;
            dcnt  <= '0;
        end else begin
            dcnt <= dcnt + DCNT_ONE;
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Measures high/low phase durations of a debounced board input and
// presents each completed high+low pair on a single-entry valid/ready slot.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   in_signal     raw asynchronous input
//   level         debounced level
//   meas_valid    a pair is held on meas_high/meas_low
//   meas_ready    consumer accepts the pair while meas_valid is high
//   meas_high     high-phase duration in cycles (saturating)
//   meas_low      low-phase duration in cycles (saturating)
//   meas_sat      either duration of the held pair saturated
//   meas_dropped  a completed pair was lost since the last accepted transfer
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first rising edge of level after reset
// HIGH  | counting cycles of the current high phase
// LOW   | counting cycles of the low phase that follows a captured high
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_WIDTH       = 24,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_signal,
    output logic                 level,
    output logic                 meas_valid,
    input  logic                 meas_ready,
    output logic [CNT_WIDTH-1:0] meas_high,
    output logic [CNT_WIDTH-1:0] meas_low,
    output logic                 meas_sat,
    output logic                 meas_dropped
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    meterState_t          state;
    meterState_t          stateNext;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cntNext;
    logic [CNT_WIDTH-1:0] hiReg;
    logic                 hiSat;
    logic                 levelD;
    logic                 rise;
    logic                 fall;
    logic                 captureHigh;
    logic                 pairDone;
    logic                 slotFree;
    logic                 transfer;

    input_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) uDebounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_signal (in_signal),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            levelD <= 1'b0;
        end else begin
            levelD <= level;
        end
    end

    assign rise = level & ~levelD;
    assign fall = ~level & levelD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // The edge cycle itself is the first cycle of the new phase, hence the
    // restart at 1; the captured count is the value before that restart.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        captureHigh = 1'b0;
        pairDone    = 1'b0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (rise) begin
                    stateNext = HIGH;
                    cntNext   = CNT_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    captureHigh = 1'b1;
                    stateNext   = LOW;
                    cntNext     = CNT_ONE;
                end else begin
                    cntNext = satInc(cnt);
                end
            end
            LOW: begin
                if (rise) begin
                    pairDone  = 1'b1;
                    stateNext = HIGH;
                    cntNext   = CNT_ONE;
                end else begin
                    cntNext = satInc(cnt);
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hiReg <= '0;
            hiSat <= 1'b0;
        end else if (captureHigh && isMeasuring(state)) begin
            hiReg <= cnt;
            hiSat <= (cnt == CNT_MAX);
        end
    end

    // A transfer in the completion cycle frees the slot, so a new pair can
    // replace the one being accepted without counting as a drop.
    assign transfer = meas_valid & meas_ready;
    assign slotFree = ~meas_valid | meas_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_valid   <= 1'b0;
            meas_high    <= '0;
            meas_low     <= '0;
            meas_sat     <= 1'b0;
            meas_dropped <= 1'b0;
        end else begin
            if (pairDone && slotFree) begin
                meas_valid <= 1'b1;
                meas_high  <= hiReg;
                meas_low   <= cnt;
                meas_sat   <= hiSat | (cnt == CNT_MAX);
            end else if (transfer) begin
                meas_valid <= 1'b0;
            end

            if (pairDone && !slotFree) begin
                meas_dropped <= 1'b1;
            end else if (transfer) begin
                meas_dropped <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
Input-side counterpart to the board's LED/blink output path. Samples an asynchronous single-bit board signal, such as a button or an external blink source, through a synchronizer and debounce filter. Measures the duration of each high phase and the following low phase in clock cycles. Presents each completed high/low pair on a valid/ready output port for the processor or a status block to read.

Parameters:
CNT_WIDTH, 24, width of the high/low duration counters and outputs.
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before the filtered level changes (legal range 1 to 2^16-1).
SYNC_STAGES, 2, number of flip-flop synchronizer stages (legal range 2 or more).

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
in_signal  input  1  asynchronous raw input.
level  output  1  debounced, filtered level.
meas_valid  output  1  a measurement pair is held on meas_high/meas_low.
meas_ready  input  1  consumer accepts the pair when asserted with meas_valid.
meas_high  output  CNT_WIDTH  high-phase duration in cycles.
meas_low  output  CNT_WIDTH  low-phase duration in cycles.
meas_sat  output  1  either duration in this pair saturated.
meas_dropped  output  1  at least one pair was lost since the last accepted transfer.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Synchronizer flops, level, counters, meas_valid, meas_high, meas_low, meas_sat and meas_dropped all go to 0.
  - FSM goes to IDLE.
  - Reset mid-measurement discards all partial counts; no pair is emitted.
- Synchronizer: SYNC_STAGES flops in series, each reset to 0. sync_out lags in_signal by SYNC_STAGES cycles.
- Debounce filter:
  - Counter dcnt increments each cycle that sync_out != level.
  - dcnt resets to 0 on any cycle where sync_out == level.
  - When sync_out != level and dcnt == DEBOUNCE_CYCLES-1, level toggles on that edge and dcnt clears.
  - A clean input edge therefore reaches level after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - Pulses shorter than DEBOUNCE_CYCLES cycles never change level.
- Edge detect: rise = level & ~level_d; fall = ~level & level_d. level_d is level registered once, reset 0.
- FSM states:
  - IDLE: wait for the first rise. Any partial high phase present at reset is ignored. On rise: go to HIGH, cnt<=1.
  - HIGH: cnt<=sat_inc(cnt) each cycle. On fall: hi_reg<=cnt, hi_sat<=(cnt==all-ones), go to LOW, cnt<=1.
  - LOW: cnt<=sat_inc(cnt). On rise: the pair is complete (high=hi_reg, low=cnt); go to HIGH, cnt<=1.
- Counting rule: captured value equals the number of cycles level was in that state.
- Saturation: sat_inc holds at 2^CNT_WIDTH-1 and never wraps. meas_sat = hi_sat | (low count == all-ones).
- Output slot: single entry.
  - Slot is free when meas_valid==0, or meas_valid & meas_ready in the same cycle.
  - On pair completion with slot free: load meas_high/meas_low/meas_sat and set meas_valid=1.
  - On pair completion with slot occupied: slot contents unchanged, meas_dropped<=1.
  - Completion and transfer in the same cycle count as free: the new pair replaces the old one, meas_valid stays 1, no drop.
  - Transfer: meas_valid & meas_ready clears meas_valid (unless reloaded) and clears meas_dropped. If a drop occurs in the same cycle, meas_dropped stays 1 (the set wins).
- Outputs hold stable while meas_valid=1 and meas_ready=0.
- meas_ready is ignored when meas_valid=0.
- Output latency: meas_valid rises 1 cycle after the rise edge that completes the pair.

Decomposition:
- Package pulse_meter_pkg holds:
  - state typedef (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - 2'd3 treated as illegal, recovers to IDLE.
- Sub-module input_debounce holds:
  - synchronizer and debounce filter;
  - parameters SYNC_STAGES and DEBOUNCE_CYCLES;
  - ports clk, rst_n, in_signal, level.
- Top holds the edge detect, FSM, counters and output slot.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_signal=1 -> all outputs 0. After release with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, level rises exactly 6 cycles later. FSM goes to HIGH but no pair is emitted until a full high+low period completes.
- Clean period: DEBOUNCE_CYCLES=4, meas_ready=1, in_signal high 100 / low 300 cycles, repeated -> meas_high=100, meas_low=300, meas_sat=0. meas_valid is a 1-cycle pulse per period.
- Glitch rejection: DEBOUNCE_CYCLES=4, 3-cycle high pulse during a low phase -> level unchanged, meas_low counts straight through. A 4-cycle pulse does produce a level change.
- Saturation: CNT_WIDTH=8, high 300 / low 50 -> meas_high=255, meas_low=50, meas_sat=1.
- Backpressure: meas_ready=0 across two complete periods (40/60 then 70/80) -> outputs hold 40/60 and meas_dropped=1. Then meas_ready=1 for one cycle -> transfer occurs, meas_valid=0, meas_dropped=0.
- Reset mid-measurement: assert rst_n=0 during LOW after 50 cycles -> no meas_valid. The next full period is measured exactly (e.g. 20/30).
